// File: rtl/cpu7_ifu_ibus.sv
// Instruction-fetch bus adapter: one outstanding single-word fetch, redirect (cancel) handling, ADEF on misaligned PC.
// Define CPU7_IFU_IBUS_RESP_REG_EN to register the response one cycle after ibus_rvalid.
module cpu7_ifu_ibus (
  input  logic         clock,
  input  logic         reset,
  input  logic         inst_req,
  input  logic [31:0]  inst_addr,
  input  logic         inst_cancel,
  output logic         inst_addr_ok,
  output logic         inst_valid,
  output logic         inst_ex,
  output logic [5:0]   inst_exccode,
  output logic [127:0] inst_rdata,
  output logic [1:0]   inst_count,
  output logic         inst_uncache,
  output logic         ibus_req,
  output logic [31:0]  ibus_addr,
  input  logic         ibus_gnt,
  input  logic         ibus_rvalid,
  input  logic [31:0]  ibus_rdata,
  input  logic         ibus_err
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned CODE_W = 6;
  localparam int unsigned PAD_W  = 128 - WORD_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_GNT  = 3'd1;
  localparam logic [2:0] WAIT_RESP = 3'd2;
  localparam logic [2:0] DROP      = 3'd3;
  localparam logic [2:0] ALIGN_EX  = 3'd4;

  localparam logic [CODE_W-1:0] EXC_NONE = 6'h00;
  localparam logic [CODE_W-1:0] EXC_ADEF = 6'h08;
  localparam logic [CODE_W-1:0] EXC_BUS  = 6'h0A;

  logic [2:0]        state, state_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic              drop_q, drop_nxt;

  logic              resp_valid_c;
  logic              resp_ex_c;
  logic [CODE_W-1:0] resp_code_c;
  logic [WORD_W-1:0] resp_word_c;

  // Next state, bus handshake and unregistered response
  always_comb begin
    state_nxt    = state;
    addr_nxt     = addr_q;
    drop_nxt     = drop_q;
    ibus_req     = 1'b0;
    ibus_addr    = addr_q;
    inst_addr_ok = 1'b0;
    resp_valid_c = 1'b0;
    resp_ex_c    = 1'b0;
    resp_code_c  = EXC_NONE;
    resp_word_c  = '0;
    case (state)
      IDLE: begin
        if (inst_req && !inst_cancel) begin
          addr_nxt = inst_addr;
          if (inst_addr[1:0] == 2'b00) begin
            ibus_req  = 1'b1;
            ibus_addr = inst_addr;
            if (ibus_gnt) begin
              inst_addr_ok = 1'b1;
              state_nxt    = WAIT_RESP;
            end else begin
              state_nxt = WAIT_GNT;
            end
          end else begin
            inst_addr_ok = 1'b1;
            state_nxt    = ALIGN_EX;
          end
        end
      end
      WAIT_GNT: begin
        ibus_req = 1'b1;
        if (inst_cancel) drop_nxt = 1'b1;
        // A granted-but-cancelled request must still drain its response
        if (ibus_gnt) begin
          inst_addr_ok = 1'b1;
          drop_nxt     = 1'b0;
          state_nxt    = (drop_q || inst_cancel) ? DROP : WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (ibus_rvalid) begin
          state_nxt = IDLE;
          if (!inst_cancel) begin
            resp_valid_c = 1'b1;
            resp_ex_c    = ibus_err;
            resp_code_c  = ibus_err ? EXC_BUS : EXC_NONE;
            resp_word_c  = ibus_rdata;
          end
        end else if (inst_cancel) begin
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (ibus_rvalid) state_nxt = IDLE;
      end
      ALIGN_EX: begin
        state_nxt = IDLE;
        if (!inst_cancel) begin
          resp_valid_c = 1'b1;
          resp_ex_c    = 1'b1;
          resp_code_c  = EXC_ADEF;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (reset) begin
      ibus_req     = 1'b0;
      inst_addr_ok = 1'b0;
      resp_valid_c = 1'b0;
      resp_ex_c    = 1'b0;
      resp_code_c  = EXC_NONE;
      resp_word_c  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      addr_q <= '0;
      drop_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      addr_q <= addr_nxt;
      drop_q <= drop_nxt;
    end
  end

  logic out_valid;

`ifdef CPU7_IFU_IBUS_RESP_REG_EN
  logic              resp_valid_q;
  logic              resp_ex_q;
  logic [CODE_W-1:0] resp_code_q;
  logic [WORD_W-1:0] resp_word_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      resp_valid_q <= 1'b0;
      resp_ex_q    <= 1'b0;
      resp_code_q  <= EXC_NONE;
      resp_word_q  <= '0;
    end else begin
      resp_valid_q <= resp_valid_c;
      resp_ex_q    <= resp_ex_c;
      resp_code_q  <= resp_code_c;
      resp_word_q  <= resp_word_c;
    end
  end

  // A redirect in the presentation cycle still kills the registered response
  assign out_valid    = resp_valid_q && !inst_cancel && !reset;
  assign inst_ex      = out_valid && resp_ex_q;
  assign inst_exccode = out_valid ? resp_code_q : EXC_NONE;
  assign inst_rdata   = out_valid ? {PAD_W'(0), resp_word_q} : '0;
`else
  assign out_valid    = resp_valid_c;
  assign inst_ex      = resp_ex_c;
  assign inst_exccode = resp_code_c;
  assign inst_rdata   = {PAD_W'(0), resp_word_c};
`endif

  assign inst_valid   = out_valid;
  assign inst_count   = 2'd1;
  assign inst_uncache = 1'b1;

endmodule

// File: tb/tb_cpu7_ifu_ibus.sv
// Self-checking bench for cpu7_ifu_ibus: directed scenarios plus randomized fetches against a transaction-level model.
module tb_cpu7_ifu_ibus;

`ifdef CPU7_IFU_IBUS_RESP_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         inst_req;
  logic [31:0]  inst_addr;
  logic         inst_cancel;
  logic         inst_addr_ok;
  logic         inst_valid;
  logic         inst_ex;
  logic [5:0]   inst_exccode;
  logic [127:0] inst_rdata;
  logic [1:0]   inst_count;
  logic         inst_uncache;
  logic         ibus_req;
  logic [31:0]  ibus_addr;
  logic         ibus_gnt;
  logic         ibus_rvalid;
  logic [31:0]  ibus_rdata;
  logic         ibus_err;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  cpu7_ifu_ibus dut (
    .clock(clock), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_valid(inst_valid), .inst_ex(inst_ex),
    .inst_exccode(inst_exccode), .inst_rdata(inst_rdata), .inst_count(inst_count),
    .inst_uncache(inst_uncache), .ibus_req(ibus_req), .ibus_addr(ibus_addr),
    .ibus_gnt(ibus_gnt), .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
    .ibus_err(ibus_err)
  );

  // Start a new cycle and apply every input for it
  task automatic drive(input logic rst, input logic req, input logic [31:0] addr,
                       input logic cancel, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    @(posedge clock);
    #1;
    reset = rst; inst_req = req; inst_addr = addr; inst_cancel = cancel;
    ibus_gnt = gnt; ibus_rvalid = rv; ibus_rdata = rdata; ibus_err = err;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      drive(k < 2, 1'b1, 32'h1C00_0000, 1'b0, 1'b1, 1'b1, $urandom, 1'b1);
      @(negedge clock);
      total++;
      if ({ibus_req, inst_addr_ok, inst_valid, inst_ex, inst_exccode, inst_rdata} !== '0 && k < 2) begin
        $display("FAIL reset_outputs cycle %0d: got req=%b ok=%b v=%b ex=%b code=%h rdata=%h, want all zero",
                 k, ibus_req, inst_addr_ok, inst_valid, inst_ex, inst_exccode, inst_rdata);
      end else if (k == 2 && (ibus_req !== 1'b1 || inst_addr_ok !== 1'b1 || inst_valid !== 1'b0)) begin
        $display("FAIL reset_release: got req=%b ok=%b v=%b, want 1 1 0", ibus_req, inst_addr_ok, inst_valid);
      end else passed++;
    end
    // Drain the fetch started on reset release
    drive(1'b0, 1'b0, 32'h1C00_0000, 1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
    for (int k = 0; k < LAT; k++) drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    total++;
    if (inst_count !== 2'd1 || inst_uncache !== 1'b1) begin
      $display("FAIL constants: got count=%0d uncache=%b, want 1 1", inst_count, inst_uncache);
    end else passed++;
  endtask

  // One aligned fetch: grant after gd cycles, rvalid rd cycles later, optional one-cycle cancel
  task automatic test_fetch(input logic [31:0] addr, input int gd, input int rd,
                            input logic [31:0] data, input logic err, input int cancel_at);
    int rv;
    bit delivered;
    logic [135:0] exp_r;
    logic [135:0] got_r;
    rv = gd + rd;
    delivered = !(cancel_at >= 1 && cancel_at <= rv + LAT);
    for (int k = 0; k <= rv + LAT; k++) begin
      drive(1'b0, k == 0, addr, k == cancel_at, k == gd, k == rv,
            (k == rv) ? data : $urandom, (k == rv) ? err : 1'($urandom));
      @(negedge clock);
      total++;
      if (ibus_req !== (k <= gd) || (k <= gd && ibus_addr !== addr) || inst_addr_ok !== (k == gd)) begin
        $display("FAIL fetch_handshake addr=%h cycle %0d: got req=%b addr=%h ok=%b, want req=%b addr=%h ok=%b",
                 addr, k, ibus_req, ibus_addr, inst_addr_ok, k <= gd, addr, k == gd);
      end else passed++;
      exp_r = (delivered && k == rv + LAT) ? {1'b1, err, (err ? 6'h0A : 6'h00), 96'b0, data} : '0;
      got_r = {inst_valid, inst_ex, inst_exccode, inst_rdata};
      total++;
      if (got_r !== exp_r) begin
        $display("FAIL fetch_response addr=%h cycle %0d: got %h, want %h", addr, k, got_r, exp_r);
      end else passed++;
    end
  endtask

  // Misaligned PC: ADEF next cycle (plus LAT), optional cancel, stray rvalid must be ignored
  task automatic test_align(input logic [31:0] addr, input bit cancel, input bit stray);
    logic [135:0] exp_r;
    logic [135:0] got_r;
    for (int k = 0; k <= 1 + LAT; k++) begin
      drive(1'b0, k == 0, addr, cancel && k == 1 + LAT, 1'($urandom), stray && k == 1,
            $urandom, 1'b1);
      @(negedge clock);
      total++;
      if (ibus_req !== 1'b0 || inst_addr_ok !== (k == 0)) begin
        $display("FAIL align_handshake addr=%h cycle %0d: got req=%b ok=%b, want req=0 ok=%b",
                 addr, k, ibus_req, inst_addr_ok, k == 0);
      end else passed++;
      exp_r = (!cancel && k == 1 + LAT) ? {1'b1, 1'b1, 6'h08, 128'b0} : '0;
      got_r = {inst_valid, inst_ex, inst_exccode, inst_rdata};
      total++;
      if (got_r !== exp_r) begin
        $display("FAIL align_response addr=%h cycle %0d: got %h, want %h", addr, k, got_r, exp_r);
      end else passed++;
    end
  endtask

  // Reset while waiting for data; the late rvalid belongs to nobody
  task automatic test_reset_midflight();
    drive(1'b0, 1'b1, 32'h1C00_0100, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int k = 1; k <= 4 + LAT; k++) begin
      drive(k == 1, 1'b0, 32'h1C00_0100, 1'b0, 1'b0, k == 3, 32'hDEAD_BEEF, 1'b0);
      @(negedge clock);
      total++;
      if (inst_valid !== 1'b0 || inst_rdata !== '0 || ibus_req !== 1'b0) begin
        $display("FAIL reset_midflight cycle %0d: got v=%b rdata=%h req=%b, want 0 0 0",
                 k, inst_valid, inst_rdata, ibus_req);
      end else passed++;
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a;
    int gd, rd, c;
    for (int i = 0; i < n; i++) begin
      a = $urandom;
      if ($urandom_range(5, 0) == 0) begin
        a[1:0] = 2'($urandom_range(3, 1));
        test_align(a, $urandom_range(3, 0) == 0, 1'($urandom));
      end else begin
        a[1:0] = 2'b00;
        gd = $urandom_range(3, 0);
        rd = $urandom_range(3, 1);
        c  = ($urandom_range(2, 0) == 0) ? $urandom_range(gd + rd + LAT + 1, 1) : -1;
        test_fetch(a, gd, rd, $urandom, $urandom_range(3, 0) == 0, c);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    ibus_gnt = 1'b0; ibus_rvalid = 1'b0; ibus_rdata = '0; ibus_err = 1'b0;
    test_reset();
    test_fetch(32'h1C00_0000, 0, 2, 32'h0280_0400, 1'b0, -1);
    test_fetch(32'h1C00_0010, 3, 1, 32'h1234_5678, 1'b0, -1);
    test_fetch(32'h1C00_0020, 0, 2, 32'hCAFE_F00D, 1'b0, 1);
    test_fetch(32'h1C00_0040, 0, 1, 32'h0000_0001, 1'b0, -1);
    test_fetch(32'h1C00_0050, 2, 2, 32'h0BAD_0BAD, 1'b0, 1);
    test_align(32'h1C00_0002, 1'b0, 1'b1);
    test_align(32'h1C00_0003, 1'b1, 1'b0);
    test_fetch(32'h1C00_0060, 1, 1, 32'h5555_AAAA, 1'b1, -1);
    test_fetch(32'h1C00_0070, 0, 1, 32'h7777_7777, 1'b0, 1);
    test_fetch(32'h1C00_0080, 0, 2, 32'h8888_8888, 1'b0, 2 + LAT);
    test_reset_midflight();
    test_random(60);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_ibus.md
CPU7_IFU_IBUS -- requirements
Module: cpu7_ifu_ibus

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports: inst_req  in  1  fetch request from the fetch datapath.
REQ-004 SHALL have ports: inst_addr  in  32  fetch PC; held stable by the requester until inst_valid.
REQ-005 SHALL have ports: inst_cancel  in  1  branch redirect; kill the pending fetch.
REQ-006 SHALL have ports: inst_addr_ok  out  1  request accepted this cycle.
REQ-007 SHALL have ports: inst_valid, inst_ex  out  1 each  response valid; response is an exception.
REQ-008 SHALL have ports: inst_exccode  out  6  exception code, valid with inst_ex.
REQ-009 SHALL have ports: inst_rdata  out  128  {96'b0, word}; inst_count  out  2  constant 2'd1; inst_uncache  out  1  constant 1'b1.
REQ-010 SHALL have ports: ibus_req  out  1, ibus_addr  out  32, ibus_gnt  in  1  memory-side request/grant.
REQ-011 SHALL have ports: ibus_rvalid  in  1, ibus_rdata  in  32, ibus_err  in  1  memory-side read response.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RESP, DROP, ALIGN_EX; at most one bus transaction outstanding.
REQ-013 SHALL in IDLE with inst_req=1, inst_cancel=0, inst_addr[1:0]=0: assert ibus_req combinationally, ibus_addr=inst_addr; go WAIT_RESP if ibus_gnt, else WAIT_GNT with address latched.
REQ-014 SHALL pulse inst_addr_ok=1 in exactly the cycle ibus_req&ibus_gnt.
REQ-015 SHALL in WAIT_GNT hold ibus_req=1 and ibus_addr at the latched value until ibus_gnt; never withdraw a request.
REQ-016 SHALL on inst_cancel in WAIT_GNT record a drop flag; on grant go DROP instead of WAIT_RESP.
REQ-017 SHALL in WAIT_RESP on ibus_rvalid (no cancel): return inst_valid=1, inst_rdata[31:0]=ibus_rdata, inst_ex=ibus_err, inst_exccode=6'h0A if err else 6'h00; go IDLE.
REQ-018 SHALL on inst_cancel in WAIT_RESP without rvalid go DROP; with rvalid in the same cycle suppress inst_valid and go IDLE.
REQ-019 SHALL in DROP ignore inst_cancel, keep inst_valid=0, and return to IDLE on ibus_rvalid.
REQ-020 SHALL in IDLE with inst_req=1, inst_addr[1:0]!=0, no cancel: issue no bus request, assert inst_addr_ok, go ALIGN_EX; next cycle inst_valid=1, inst_ex=1, inst_exccode=6'h08 (ADEF), inst_rdata=0; go IDLE. Cancel in ALIGN_EX suppresses the response.
REQ-021 SHALL ignore ibus_rvalid arriving in IDLE/WAIT_GNT/ALIGN_EX (no inst_valid).
REQ-022 SHALL not start a new request in the cycle a response is returned; best-case throughput is one fetch per 2 cycles.
REQ-023 SHALL drive inst_valid=0, inst_ex=0, inst_exccode=0, inst_rdata=0 when no response returns.

Reset
REQ-024 SHALL on reset=1 force IDLE, clear drop flag and latched address; reset-cycle outputs: ibus_req=0, inst_addr_ok=0, inst_valid=0, inst_ex=0, inst_exccode=0, inst_rdata=0.
REQ-025 SHALL on reset mid-transaction abandon it; a later stray ibus_rvalid is ignored per REQ-021.

Configuration
REQ-026 SHALL with CPU7_IFU_IBUS_RESP_REG_EN defined register the response (inst_valid/inst_ex/inst_exccode/inst_rdata) one cycle after ibus_rvalid; FSM transitions unchanged; a cancel in the registered cycle clears the registered inst_valid.
REQ-027 SHALL without CPU7_IFU_IBUS_RESP_REG_EN pass the response combinationally in the ibus_rvalid cycle.

Verification
REQ-028 SHALL cover: reset then inst_req=1, addr=0x1C000000, gnt same cycle, rvalid 2 cycles later rdata=0x02800400 -> inst_addr_ok cycle 0, inst_valid with inst_rdata[31:0]=0x02800400, inst_ex=0.
REQ-029 SHALL cover: gnt delayed 3 cycles -> ibus_req/ibus_addr stable 4 cycles, single inst_addr_ok pulse.
REQ-030 SHALL cover: inst_cancel one cycle after grant, rvalid 2 cycles later -> no inst_valid; next request addr=0x1C000040 issued cycle after the dropped rvalid.
REQ-031 SHALL cover: inst_addr=0x1C000002 -> no ibus_req, inst_valid next cycle with inst_ex=1, inst_exccode=6'h08.
REQ-032 SHALL cover: rvalid with ibus_err=1 -> inst_valid=1, inst_ex=1, inst_exccode=6'h0A; cancel coincident with rvalid -> inst_valid=0.
REQ-033 SHALL cover: reset asserted in WAIT_RESP, stray rvalid after release -> no inst_valid; both macro settings run, response latency differs by exactly one cycle.
